cim_array_ctrl: RTL and testbench

Command sequencer for a bank of NUM_COLS CIM columns that share one set of row data lines. It accepts write and MAC commands over a valid/ready interface and drives the shared array controls: en, one-hot column select, write_en, data_lines and data_lines_n. For MAC commands it steps over a range of columns, waits for each column's acc_ready, captures the column result and returns it on a valid/ready result stream.

---
 rtl/cim_pkg.sv | 24 ++
 rtl/cim_col_onehot.sv | 27 ++
 rtl/cim_array_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_cim_array_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// Shared definitions for the CIM column-bank command sequencer:
// command opcode encoding, sequencer state encoding and default bank geometry.
package cim_pkg;

    localparam int CIM_NUM_COLS       = 8;
    localparam int CIM_NUM_ROWS       = 32;
    localparam int CIM_DATA_WIDTH     = 9;
    localparam int CIM_ODATA_WIDTH    = 21;
    localparam int CIM_TIMEOUT_CYCLES = 255;

    typedef enum logic {
        CIM_OP_WRITE = 1'b0,
        CIM_OP_MAC   = 1'b1
    } cim_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUTPUT = 3'd4
    } cim_state_e;

endpackage

// File: rtl/cim_col_onehot.sv
// Column index to one-hot select decoder; all-zero output when disabled.
module cim_col_onehot #(
    parameter int NUM_COLS = 8,
    parameter int COL_W    = $clog2(NUM_COLS)
) (
    input  logic                en,
    input  logic [COL_W-1:0]    idx,
    output logic [NUM_COLS-1:0] onehot
);

    // Decode the column index into a single asserted select bit
    always_comb begin
        onehot = {NUM_COLS{1'b0}};
        if (en) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                if (32'(idx) == 32'(i)) begin
                    onehot[i] = 1'b1;
                end else begin
                    onehot[i] = 1'b0;
                end
            end
        end else begin
            onehot = {NUM_COLS{1'b0}};
        end
    end

endmodule

// File: rtl/cim_array_ctrl.sv
// Command sequencer for a bank of CIM columns sharing one set of row data lines.
// Accepts WRITE / MAC commands, drives the shared array controls, sweeps MAC
// commands over a clamped column range and returns one result per column.
// Optional build macro CIM_CTRL_TIMEOUT_EN adds an acc_ready watchdog in WAIT:
// on expiry err is set and a zero result is emitted for that column.
module cim_array_ctrl
    import cim_pkg::*;
#(
    parameter int NUM_COLS       = CIM_NUM_COLS,
    parameter int NUM_ROWS       = CIM_NUM_ROWS,
    parameter int DATA_WIDTH     = CIM_DATA_WIDTH,
    parameter int ODATA_WIDTH    = CIM_ODATA_WIDTH,
    parameter int COL_W          = $clog2(NUM_COLS),
    parameter int TIMEOUT_CYCLES = CIM_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_op,
    input  logic [COL_W-1:0]               cmd_col,
    input  logic [COL_W-1:0]               cmd_last_col,
    input  logic [NUM_ROWS*DATA_WIDTH-1:0] cmd_data,
    output logic                           col_en,
    output logic [NUM_COLS-1:0]            col_sel,
    output logic                           col_write_en,
    output logic [NUM_ROWS*DATA_WIDTH-1:0] data_lines,
    output logic [NUM_ROWS*DATA_WIDTH-1:0] data_lines_n,
    input  logic [NUM_COLS*ODATA_WIDTH-1:0] col_result,
    input  logic [NUM_COLS-1:0]            col_acc_ready,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [ODATA_WIDTH-1:0]         res_data,
    output logic [COL_W-1:0]               res_col,
    output logic                           res_last,
    output logic                           busy,
    output logic                           err
);

    localparam int DW = NUM_ROWS * DATA_WIDTH;

    cim_state_e           state_r;
    logic [COL_W-1:0]     cur_r;
    logic [COL_W-1:0]     last_r;

    logic [31:0]          cmd_col_ext_s;
    logic [31:0]          cmd_last_ext_s;
    logic [31:0]          last_clip_s;
    logic [COL_W-1:0]     last_calc_s;
    logic                 col_legal_s;
    logic                 cmd_fire_s;
    logic [COL_W-1:0]     onehot_idx_s;
    logic [NUM_COLS-1:0]  onehot_s;
    logic [ODATA_WIDTH-1:0] sel_result_s;
    logic                 sel_ready_s;

`ifdef CIM_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]     tmo_cnt_r;
`else
    // The watchdog limit only matters when the watchdog is built in.
    logic                 cfg_unused_s;
    assign cfg_unused_s = (TIMEOUT_CYCLES != 32'sd0);
`endif

    // Command legality, clamped sweep end and the selected column's result/ready
    always_comb begin
        cmd_col_ext_s  = 32'(cmd_col);
        cmd_last_ext_s = 32'(cmd_last_col);
        col_legal_s    = (cmd_col_ext_s < 32'(NUM_COLS));
        cmd_fire_s     = cmd_valid && cmd_ready;
        if (cmd_last_ext_s > 32'(NUM_COLS - 1)) begin
            last_clip_s = 32'(NUM_COLS - 1);
        end else begin
            last_clip_s = cmd_last_ext_s;
        end
        // A sweep never runs backwards: an end before the start means one column.
        if (last_clip_s < cmd_col_ext_s) begin
            last_calc_s = COL_W'(cmd_col_ext_s);
        end else begin
            last_calc_s = COL_W'(last_clip_s);
        end
        sel_result_s = col_result[cur_r*ODATA_WIDTH +: ODATA_WIDTH];
        sel_ready_s  = col_acc_ready[cur_r];
    end

    // Column whose select is loaded next: the following sweep column when
    // leaving OUTPUT, otherwise the commanded column.
    always_comb begin
        if (state_r == ST_OUTPUT) begin
            onehot_idx_s = cur_r + COL_W'(1);
        end else begin
            onehot_idx_s = cmd_col;
        end
    end

    cim_col_onehot #(
        .NUM_COLS (NUM_COLS),
        .COL_W    (COL_W)
    ) u_onehot (
        .en     (1'b1),
        .idx    (onehot_idx_s),
        .onehot (onehot_s)
    );

    // Sequencer FSM with all array controls and result outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cur_r        <= {COL_W{1'b0}};
            last_r       <= {COL_W{1'b0}};
            cmd_ready    <= 1'b1;
            col_en       <= 1'b0;
            col_sel      <= {NUM_COLS{1'b0}};
            col_write_en <= 1'b0;
            data_lines   <= {DW{1'b0}};
            data_lines_n <= {DW{1'b1}};
            res_valid    <= 1'b0;
            res_data     <= {ODATA_WIDTH{1'b0}};
            res_col      <= {COL_W{1'b0}};
            res_last     <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
`ifdef CIM_CTRL_TIMEOUT_EN
            tmo_cnt_r    <= {TMO_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_fire_s) begin
                        data_lines   <= cmd_data;
                        data_lines_n <= ~cmd_data;
                        if (!col_legal_s) begin
                            err <= 1'b1;
                        end else if (cmd_op == CIM_OP_WRITE) begin
                            state_r      <= ST_WRITE;
                            col_en       <= 1'b1;
                            col_write_en <= 1'b1;
                            col_sel      <= onehot_s;
                            cmd_ready    <= 1'b0;
                            busy         <= 1'b1;
                        end else begin
                            state_r   <= ST_ISSUE;
                            cur_r     <= cmd_col;
                            last_r    <= last_calc_s;
                            col_en    <= 1'b1;
                            col_sel   <= onehot_s;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    state_r      <= ST_IDLE;
                    col_en       <= 1'b0;
                    col_write_en <= 1'b0;
                    col_sel      <= {NUM_COLS{1'b0}};
                    cmd_ready    <= 1'b1;
                    busy         <= 1'b0;
                end
                ST_ISSUE: begin
                    // acc_ready may still carry the previous operation's flag here
                    state_r <= ST_WAIT;
`ifdef CIM_CTRL_TIMEOUT_EN
                    tmo_cnt_r <= {TMO_W{1'b0}};
`endif
                end
                ST_WAIT: begin
                    if (sel_ready_s) begin
                        state_r   <= ST_OUTPUT;
                        res_data  <= sel_result_s;
                        res_col   <= cur_r;
                        res_last  <= (cur_r == last_r);
                        res_valid <= 1'b1;
                        col_en    <= 1'b0;
                        col_sel   <= {NUM_COLS{1'b0}};
`ifdef CIM_CTRL_TIMEOUT_EN
                    end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_r   <= ST_OUTPUT;
                        err       <= 1'b1;
                        res_data  <= {ODATA_WIDTH{1'b0}};
                        res_col   <= cur_r;
                        res_last  <= (cur_r == last_r);
                        res_valid <= 1'b1;
                        col_en    <= 1'b0;
                        col_sel   <= {NUM_COLS{1'b0}};
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
`endif
                    end
                end
                ST_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (res_last) begin
                            state_r   <= ST_IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state_r <= ST_ISSUE;
                            cur_r   <= cur_r + COL_W'(1);
                            col_en  <= 1'b1;
                            col_sel <= onehot_s;
                        end
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    col_en       <= 1'b0;
                    col_sel      <= {NUM_COLS{1'b0}};
                    col_write_en <= 1'b0;
                    res_valid    <= 1'b0;
                    cmd_ready    <= 1'b1;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cim_array_ctrl.sv
// Scoreboard bench for cim_array_ctrl: expected results are queued when a MAC
// command is issued; a monitor pops and compares on each result handshake.
// A column responder raises acc_ready a set number of cycles after select.
module tb_cim_array_ctrl;

    localparam int NC  = 8;
    localparam int NR  = 32;
    localparam int DWD = 9;
    localparam int OW  = 21;
    localparam int CW  = 3;
    localparam int DW  = NR * DWD;

    typedef struct packed {
        logic [OW-1:0] data;
        logic [CW-1:0] col;
        logic          last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [CW-1:0]     cmd_col;
    logic [CW-1:0]     cmd_last_col;
    logic [DW-1:0]     cmd_data;
    logic              col_en;
    logic [NC-1:0]     col_sel;
    logic              col_write_en;
    logic [DW-1:0]     data_lines;
    logic [DW-1:0]     data_lines_n;
    logic [NC*OW-1:0]  col_result;
    logic [NC-1:0]     col_acc_ready;
    logic              res_valid;
    logic              res_ready;
    logic [OW-1:0]     res_data;
    logic [CW-1:0]     res_col;
    logic              res_last;
    logic              busy;
    logic              err;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];
    logic auto_acc = 1'b1;
    int   acc_delay = 1;
    logic [DW-1:0] wdata;

    cim_array_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_col       (cmd_col),
        .cmd_last_col  (cmd_last_col),
        .cmd_data      (cmd_data),
        .col_en        (col_en),
        .col_sel       (col_sel),
        .col_write_en  (col_write_en),
        .data_lines    (data_lines),
        .data_lines_n  (data_lines_n),
        .col_result    (col_result),
        .col_acc_ready (col_acc_ready),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_col       (res_col),
        .res_last      (res_last),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_res(input int c, input logic [OW-1:0] v);
        col_result[c*OW +: OW] = v;
    endtask

    task automatic push_exp(input logic [OW-1:0] d, input logic [CW-1:0] c, input logic l);
        exp_t e;
        e.data = d;
        e.col  = c;
        e.last = l;
        sb_q.push_back(e);
    endtask

    // Result monitor: compare against the scoreboard on every handshake
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", {43'd0, res_data}, 64'hDEAD);
                end else begin
                    e = sb_q.pop_front();
                    chk("res_data", {43'd0, res_data}, {43'd0, e.data});
                    chk("res_col", {61'd0, res_col}, {61'd0, e.col});
                    chk("res_last", {63'd0, res_last}, {63'd0, e.last});
                end
            end
        end
    endtask

    // Column model: acc_ready on the selected column acc_delay cycles after ISSUE
    task automatic responder_loop();
        int acc_cnt = 0;
        forever begin
            @(negedge clk);
            if (auto_acc) begin
                if (col_en && !col_write_en) acc_cnt++;
                else acc_cnt = 0;
                col_acc_ready = (acc_cnt > acc_delay) ? col_sel : 8'h00;
            end else begin
                acc_cnt = 0;
            end
        end
    endtask

    task automatic send(input logic op, input logic [CW-1:0] c, input logic [CW-1:0] lc,
                        input logic [DW-1:0] d);
        int n = 0;
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_col      = c;
        cmd_last_col = lc;
        cmd_data     = d;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept_wait", {63'd0, (n < 300)}, 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_q.size() != 0 || !cmd_ready || res_valid) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("drain", {63'd0, (n < 600)}, 64'd1);
    endtask

    // Negedges from acceptance until res_valid is seen
    task automatic latency(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!res_valid && k < 400);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
        chk({tag, "_col_en"}, {63'd0, col_en}, 64'd0);
        chk({tag, "_col_sel"}, {56'd0, col_sel}, 64'd0);
        chk({tag, "_write_en"}, {63'd0, col_write_en}, 64'd0);
        chk({tag, "_res_valid"}, {63'd0, res_valid}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_err"}, {63'd0, err}, 64'd0);
        chk({tag, "_dl_zero"}, {63'd0, (data_lines == {DW{1'b0}})}, 64'd1);
        chk({tag, "_dln_ones"}, {63'd0, (data_lines_n == {DW{1'b1}})}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 1'b0;
        cmd_col = 3'd0;
        cmd_last_col = 3'd0;
        cmd_data = {DW{1'b0}};
        col_acc_ready = 8'h00;
        col_result = {NC*OW{1'b0}};
        res_ready = 1'b1;
        set_res(1, 21'h1F001);
        set_res(2, 21'h00ABC);
        set_res(4, 21'h14444);
        set_res(5, 21'h05055);
        set_res(6, 21'h06066);
        set_res(7, 21'h07077);
        fork
            monitor_loop();
            responder_loop();
        join_none

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // WRITE column 3, row 0 = 0x1A5
        wdata = {DW{1'b0}};
        wdata[8:0] = 9'h1A5;
        send(1'b0, 3'd3, 3'd0, wdata);
        @(negedge clk);
        chk("wr_col_en", {63'd0, col_en}, 64'd1);
        chk("wr_write_en", {63'd0, col_write_en}, 64'd1);
        chk("wr_col_sel", {56'd0, col_sel}, 64'h08);
        chk("wr_data_lines", {63'd0, (data_lines == wdata)}, 64'd1);
        chk("wr_data_lines_n", {63'd0, (data_lines_n == ~wdata)}, 64'd1);
        chk("wr_cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
        chk("wr_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk("wr_col_en_off", {63'd0, col_en}, 64'd0);
        chk("wr_write_en_off", {63'd0, col_write_en}, 64'd0);
        chk("wr_cmd_ready_back", {63'd0, cmd_ready}, 64'd1);

        // MAC 2..2, acc_ready two cycles after ISSUE
        acc_delay = 2;
        push_exp(21'h00ABC, 3'd2, 1'b1);
        send(1'b1, 3'd2, 3'd2, wdata);
        latency(k);
        chk("mac2_latency", 64'(k), 64'd4);
        wait_drain();

        // Sweep 5..7, first result back-pressured for 10 cycles
        acc_delay = 1;
        res_ready = 1'b0;
        push_exp(21'h05055, 3'd5, 1'b0);
        push_exp(21'h06066, 3'd6, 1'b0);
        push_exp(21'h07077, 3'd7, 1'b1);
        send(1'b1, 3'd5, 3'd7, wdata);
        latency(k);
        chk("sweep_latency", 64'(k), 64'd3);
        for (int i = 0; i < 10; i++) begin
            chk("bp_res_valid", {63'd0, res_valid}, 64'd1);
            chk("bp_res_data", {43'd0, res_data}, 64'h05055);
            chk("bp_res_col", {61'd0, res_col}, 64'd5);
            chk("bp_col_en", {63'd0, col_en}, 64'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        wait_drain();

        // Stale acc_ready in ISSUE and acc_ready on an unselected column
        auto_acc = 1'b0;
        col_acc_ready = 8'h00;
        push_exp(21'h1F001, 3'd1, 1'b1);
        send(1'b1, 3'd1, 3'd1, wdata);
        @(negedge clk);
        col_acc_ready = 8'h02;
        chk("stale_issue_sel", {56'd0, col_sel}, 64'h02);
        @(negedge clk);
        chk("stale_ignored", {63'd0, res_valid}, 64'd0);
        chk("stale_col_en", {63'd0, col_en}, 64'd1);
        col_acc_ready = 8'h80;
        @(negedge clk);
        chk("other_col_ignored_a", {63'd0, res_valid}, 64'd0);
        chk("wait_col_sel", {56'd0, col_sel}, 64'h02);
        @(negedge clk);
        chk("other_col_ignored_b", {63'd0, res_valid}, 64'd0);
        col_acc_ready = 8'h02;
        @(negedge clk);
        chk("selected_captured", {63'd0, res_valid}, 64'd1);
        col_acc_ready = 8'h00;
        wait_drain();
        auto_acc = 1'b1;

        // last < first: single column; sweep to the top column ends at NUM_COLS-1
        // (a 3-bit index cannot name a column beyond 7 in an 8-column bank)
        push_exp(21'h14444, 3'd4, 1'b1);
        send(1'b1, 3'd4, 3'd1, wdata);
        wait_drain();
        push_exp(21'h06066, 3'd6, 1'b0);
        push_exp(21'h07077, 3'd7, 1'b1);
        send(1'b1, 3'd6, 3'd7, wdata);
        wait_drain();

        // Reset while waiting for acc_ready
        auto_acc = 1'b0;
        col_acc_ready = 8'h00;
        send(1'b1, 3'd0, 3'd3, wdata);
        @(negedge clk);
        @(negedge clk);
        chk("wait_busy", {63'd0, busy}, 64'd1);
        chk("wait_col_en", {63'd0, col_en}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midrst");
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_result", {63'd0, res_valid}, 64'd0);
            chk("post_rst_no_activity", {63'd0, col_en}, 64'd0);
        end

`ifdef CIM_CTRL_TIMEOUT_EN
        // acc_ready never arrives: zero result and sticky err after 255 WAIT cycles
        push_exp(21'h00000, 3'd0, 1'b1);
        send(1'b1, 3'd0, 3'd0, wdata);
        latency(k);
        chk("timeout_latency", 64'(k), 64'd257);
        chk("timeout_err", {63'd0, err}, 64'd1);
        wait_drain();
        chk("timeout_err_sticky", {63'd0, err}, 64'd1);
`else
        chk("no_err", {63'd0, err}, 64'd0);
`endif
        auto_acc = 1'b1;

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
